// File: rtl/nmos_demux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-way NMOS demux between eight requesters.
// Every grant is followed by a break-before-make gap, and an optional hold timeout forces a release.
module nmos_demux8_rr_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic       A,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       TMO
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [2:0]       ptr_r, ptr_s;
    logic [2:0]       sel_r, sel_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             a_r, a_s;
    logic             tmo_r, tmo_s;
    logic             tmo_hit_s;
    logic             release_s;
    logic [2:0]       pick_s;

    // First set request strictly after ptr, wrapping 7->0; the last winner is checked last.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic       found;
        logic [2:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        sel_s     = sel_r;
        cnt_s     = cnt_r;
        a_s       = a_r;
        tmo_s     = 1'b0;
        pick_s    = rr_pick(REQ, ptr_r);
        tmo_hit_s = (HOLD_MAX != 0) && (cnt_r == HOLD_LAST);
        release_s = DONE || !REQ[sel_r] || tmo_hit_s;
        case (state_r)
            IDLE: begin
                if (REQ != 8'h00) begin
                    state_s = GRANT;
                    a_s     = 1'b1;
                    sel_s   = pick_s;
                    ptr_s   = pick_s;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    a_s = 1'b0;
                end
            end
            GRANT: begin
                // Saturating count keeps HOLD_MAX=0 from wrapping; it never triggers release then.
                if (cnt_r != CNT_SAT) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
                if (release_s) begin
                    state_s = GAP;
                    a_s     = 1'b0;
                    tmo_s   = tmo_hit_s && !DONE && REQ[sel_r];
                end else begin
                    a_s = 1'b1;
                end
            end
            GAP: begin
                state_s = IDLE;
                a_s     = 1'b0;
            end
            default: begin
                state_s = IDLE;
                a_s     = 1'b0;
                sel_s   = 3'd0;
                ptr_s   = 3'd7;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            ptr_r   <= 3'd7;
            sel_r   <= 3'd0;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            sel_r   <= sel_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            tmo_r   <= tmo_s;
        end
    end

    assign A   = a_r;
    assign S0  = sel_r[0];
    assign S1  = sel_r[1];
    assign S2  = sel_r[2];
    assign TMO = tmo_r;

endmodule
